gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Parametrised memory-mapped GPIO peripheral; successor to the fixed 4-LED/4-switch port block.
- Configurable output and input widths; set/clear/toggle output registers; 2-flop input synchronisers.
- Per-pin rising/falling edge detection with sticky write-1-to-clear status and a level interrupt.
- Sits on the core's load/store path, selected by the address decoder, and is accessed during the core's memory state.

Parameters:
- N_OUT, 4, number of output pins (1..32)
- N_IN, 4, number of input pins (1..32)
- MEM_STATE, 3'd6, core state value in which an access is performed

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- state  input  3  core FSM state
- enabled  input  1  address decoder selects this block
- load_enable  input  1  word load in progress
- store_enable  input  1  word store in progress
- address  input  32  byte address; only address[5:2] decoded
- data_in  input  32  store data
- data_out  output  32  registered load data
- out_pins  output  N_OUT  output pin drive
- in_pins  input  N_IN  asynchronous external inputs
- irq  output  1  level interrupt

Behaviour:
- Reset value is 0 for out_pins, data_out, irq, all registers, and all synchroniser and previous-value flops.
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Access strobe: acc = enabled && state==MEM_STATE. A store takes store_enable priority if both enables are high; no access occurs if neither is high.
- All accesses are 32-bit. Sub-word ops use the word at address[5:2]. Bits above N_OUT/N_IN ignore writes and read 0.
- Register map (word offset):
  - 0x00 OUT: RW.
  - 0x04 OUT_SET: W1S, reads 0.
  - 0x08 OUT_CLR: W1C, reads 0.
  - 0x0C OUT_TGL: W1T, reads 0.
  - 0x10 IN: RO, synchronised value.
  - 0x14 RISE_EN: RW.
  - 0x18 FALL_EN: RW.
  - 0x1C STATUS: R / W1C.
  - 0x20 CTRL: bit0 = irq_en, RW.
  - 0x24..0x3C: reads 0, writes ignored.
- Store: the register updates at the clk edge where acc && store_enable. out_pins equals OUT directly, so the pin changes 1 cycle after the access edge.
- Load: data_out is captured at the acc && load_enable edge and holds its value until the next load; it is not cleared between accesses.
- Input path, for in_pins changing before edge k:
  - s1 is updated at edge k.
  - s2 (= IN) is updated at edge k+1.
  - prev is updated at edge k+2.
  - rise = s2 & ~prev & RISE_EN; fall = ~s2 & prev & FALL_EN.
  - STATUS |= rise|fall at edge k+2.
- irq = CTRL[0] && |STATUS, registered with STATUS (no extra latency).
- Simultaneous STATUS W1C and new edge on the same bit: set wins, so the bit stays 1. W1C on other bits is unaffected.
- Pulses shorter than 1 clk may be missed. A pin that toggles twice inside the sync window may produce both edges or none; this is not guaranteed.
- Clearing RISE_EN/FALL_EN does not clear existing STATUS bits.
- Reset mid-operation clears everything immediately, including pending edges.
- After reset, a pin held high produces a rise event at edge 3. It is dropped because RISE_EN = 0.

Decomposition:
- Shared package/header gpio_ctrl_defs holds the register offset constants (GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_IN, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_STATUS, GPIO_CTRL) and the MEM_STATE default.
- One sub-module, gpio_sync_edge, parametrised by width: 2-flop synchroniser plus previous-value flop. It outputs sync, rise_raw, and fall_raw.

Test Plan:
- Reset with in_pins=4'hF held high; enable RISE_EN after 5 cycles -> STATUS=0, irq=0, IN reads 0xF.
- Store OUT=0x5, then SET=0x2, CLR=0x1, TGL=0xC -> out_pins sequence 0x5, 0x7, 0x6, 0xA, each 1 cycle after its access edge.
- RISE_EN=0x1, CTRL=1; in_pins[0] 0->1 before edge k -> STATUS=0x1 and irq=1 after edge k+2; falling edge leaves STATUS unchanged.
- STATUS=0x3; store STATUS=0x1 in the same cycle a new rise on pin0 is set -> STATUS stays 0x3. A later store of 0x3 -> STATUS=0, irq=0.
- Load from offsets 0x04 and 0x30 -> data_out=0. Load IN with in_pins=0x9 stable -> data_out=0x9, held through 10 idle cycles.
- Assert rst mid-store with OUT=0xF and STATUS=0x2 -> out_pins=0, irq=0, data_out=0 immediately (asynchronous); N_OUT=8/N_IN=16 build repeats the store and edge scenarios.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO peripheral: widths, register word offsets, default access state.
package gpio_ctrl_defs;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned IDX_W   = 4;

  localparam logic [STATE_W-1:0] MEM_STATE_DEFAULT = 3'd6;

  // Word offsets, i.e. address[5:2]
  localparam logic [IDX_W-1:0] GPIO_OUT     = 4'h0;
  localparam logic [IDX_W-1:0] GPIO_SET     = 4'h1;
  localparam logic [IDX_W-1:0] GPIO_CLR     = 4'h2;
  localparam logic [IDX_W-1:0] GPIO_TGL     = 4'h3;
  localparam logic [IDX_W-1:0] GPIO_IN      = 4'h4;
  localparam logic [IDX_W-1:0] GPIO_RISE_EN = 4'h5;
  localparam logic [IDX_W-1:0] GPIO_FALL_EN = 4'h6;
  localparam logic [IDX_W-1:0] GPIO_STATUS  = 4'h7;
  localparam logic [IDX_W-1:0] GPIO_CTRL    = 4'h8;

endpackage

// File: rtl/gpio_ctrl_sync_edge.sv
// Two-flop input synchroniser plus previous-value flop with raw edge outputs.
module gpio_sync_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pins,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise_raw,
  output logic [W-1:0] fall_raw
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;

  // Synchroniser chain and previous-value history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= pins;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync     = s2;
  assign rise_raw = s2 & ~prev;
  assign fall_raw = ~s2 & prev;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: set/clear/toggle outputs, synchronised inputs, sticky edge status, level irq.
module gpio_ctrl
  import gpio_ctrl_defs::*;
#(
  parameter int unsigned          N_OUT     = 4,
  parameter int unsigned          N_IN      = 4,
  parameter logic [STATE_W-1:0]   MEM_STATE = MEM_STATE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic               enabled,
  input  logic               load_enable,
  input  logic               store_enable,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic [N_OUT-1:0]   out_pins,
  input  logic [N_IN-1:0]    in_pins,
  output logic               irq
);

  logic             acc;
  logic             wr;
  logic             rd;
  logic [IDX_W-1:0] idx;
  logic [N_OUT-1:0] w_out;
  logic [N_IN-1:0]  w_in;

  logic [N_OUT-1:0] out_q;
  logic [N_IN-1:0]  rise_en_q;
  logic [N_IN-1:0]  fall_en_q;
  logic [N_IN-1:0]  status_q;
  logic             irq_en_q;

  logic [N_OUT-1:0] out_n;
  logic [N_IN-1:0]  rise_en_n;
  logic [N_IN-1:0]  fall_en_n;
  logic [N_IN-1:0]  status_n;
  logic             irq_en_n;
  logic             irq_n;
  logic [DATA_W-1:0] rd_data;

  logic [N_IN-1:0]  in_sync;
  logic [N_IN-1:0]  rise_raw;
  logic [N_IN-1:0]  fall_raw;

  // Address bits outside [5:2] and data bits above the pin widths are not decoded
  logic unused_bits;
  assign unused_bits = ^{address, data_in};

  // Access decode; a store wins when both enables are high
  assign acc   = enabled && (state == MEM_STATE);
  assign wr    = acc && store_enable;
  assign rd    = acc && load_enable && !store_enable;
  assign idx   = address[5:2];
  assign w_out = data_in[N_OUT-1:0];
  assign w_in  = data_in[N_IN-1:0];

  gpio_sync_edge #(
    .W (N_IN)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pins     (in_pins),
    .sync     (in_sync),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  // Register next-state: store decode, then edge capture (set beats W1C)
  always_comb begin
    out_n     = out_q;
    rise_en_n = rise_en_q;
    fall_en_n = fall_en_q;
    status_n  = status_q;
    irq_en_n  = irq_en_q;
    if (wr) begin
      case (idx)
        GPIO_OUT:     out_n     = w_out;
        GPIO_SET:     out_n     = out_q | w_out;
        GPIO_CLR:     out_n     = out_q & ~w_out;
        GPIO_TGL:     out_n     = out_q ^ w_out;
        GPIO_RISE_EN: rise_en_n = w_in;
        GPIO_FALL_EN: fall_en_n = w_in;
        GPIO_STATUS:  status_n  = status_q & ~w_in;
        GPIO_CTRL:    irq_en_n  = data_in[0];
        default:      ;
      endcase
    end
    status_n = status_n | (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    irq_n    = irq_en_n && (|status_n);
  end

  // Load data mux; write-only and unmapped offsets read zero
  always_comb begin
    rd_data = '0;
    case (idx)
      GPIO_OUT:     rd_data = DATA_W'(out_q);
      GPIO_IN:      rd_data = DATA_W'(in_sync);
      GPIO_RISE_EN: rd_data = DATA_W'(rise_en_q);
      GPIO_FALL_EN: rd_data = DATA_W'(fall_en_q);
      GPIO_STATUS:  rd_data = DATA_W'(status_q);
      GPIO_CTRL:    rd_data = DATA_W'(irq_en_q);
      default:      rd_data = '0;
    endcase
  end

  // Register state, load data and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= 1'b0;
      irq       <= 1'b0;
      data_out  <= '0;
    end else begin
      out_q     <= out_n;
      rise_en_q <= rise_en_n;
      fall_en_q <= fall_en_n;
      status_q  <= status_n;
      irq_en_q  <= irq_en_n;
      irq       <= irq_n;
      if (rd) begin
        data_out <= rd_data;
      end
    end
  end

  assign out_pins = out_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: vector table for register behaviour, sequences for edge/reset cases.
module tb_gpio_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic        enabled;
  logic        load_enable;
  logic        store_enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  out_pins;
  logic [3:0]  in_pins;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [3:0] R_OUT = 4'h0, R_SET = 4'h1, R_CLR = 4'h2, R_TGL = 4'h3,
                         R_IN = 4'h4, R_RISE = 4'h5, R_FALL = 4'h6, R_STAT = 4'h7,
                         R_CTRL = 4'h8;

  typedef struct {
    string       name;
    logic        wr;
    logic        en;
    logic [2:0]  st;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  exp_pins;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[18];

  gpio_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .enabled      (enabled),
    .load_enable  (load_enable),
    .store_enable (store_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .out_pins     (out_pins),
    .in_pins      (in_pins),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One access cycle; loads push the expected word and compare it once data_out updates
  task automatic access(input string name, input logic wr, input logic en, input logic [2:0] st,
                        input logic [3:0] idx, input logic [31:0] d, input logic [31:0] exp);
    state        = st;
    enabled      = en;
    store_enable = wr;
    load_enable  = !wr;
    address      = {26'd0, idx, 2'b00};
    data_in      = d;
    if (!wr) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    enabled      = 1'b0;
    store_enable = 1'b0;
    load_enable  = 1'b0;
    state        = 3'd0;
    if (!wr) begin
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL %s: scoreboard empty, got 0x%08h expected entry", name, data_out);
      end else begin
        check(name, data_out, exp_q.pop_front());
      end
    end
  endtask

  task automatic wr_reg(input logic [3:0] idx, input logic [31:0] d);
    access("store", 1'b1, 1'b1, 3'd6, idx, d, 32'd0);
  endtask

  task automatic rd_reg(input string name, input logic [3:0] idx, input logic [31:0] exp);
    access(name, 1'b0, 1'b1, 3'd6, idx, 32'd0, exp);
  endtask

  initial begin
    vecs[0]  = '{"out_wr",     1'b1, 1'b1, 3'd6, R_OUT,  32'h5,        4'h5, 32'h0};
    vecs[1]  = '{"set_wr",     1'b1, 1'b1, 3'd6, R_SET,  32'h2,        4'h7, 32'h0};
    vecs[2]  = '{"clr_wr",     1'b1, 1'b1, 3'd6, R_CLR,  32'h1,        4'h6, 32'h0};
    vecs[3]  = '{"tgl_wr",     1'b1, 1'b1, 3'd6, R_TGL,  32'hC,        4'hA, 32'h0};
    vecs[4]  = '{"out_rd",     1'b0, 1'b1, 3'd6, R_OUT,  32'h0,        4'hA, 32'hA};
    vecs[5]  = '{"set_rd",     1'b0, 1'b1, 3'd6, R_SET,  32'h0,        4'hA, 32'h0};
    vecs[6]  = '{"clr_rd",     1'b0, 1'b1, 3'd6, R_CLR,  32'h0,        4'hA, 32'h0};
    vecs[7]  = '{"tgl_rd",     1'b0, 1'b1, 3'd6, R_TGL,  32'h0,        4'hA, 32'h0};
    vecs[8]  = '{"unmap_rd",   1'b0, 1'b1, 3'd6, 4'hC,   32'h0,        4'hA, 32'h0};
    vecs[9]  = '{"in_rd",      1'b0, 1'b1, 3'd6, R_IN,   32'h0,        4'hA, 32'hF};
    vecs[10] = '{"no_en_wr",   1'b1, 1'b0, 3'd6, R_OUT,  32'h0,        4'hA, 32'h0};
    vecs[11] = '{"bad_st_wr",  1'b1, 1'b1, 3'd5, R_OUT,  32'h0,        4'hA, 32'h0};
    vecs[12] = '{"wide_wr",    1'b1, 1'b1, 3'd6, R_OUT,  32'hFFFFFFF0, 4'h0, 32'h0};
    vecs[13] = '{"wide_rd",    1'b0, 1'b1, 3'd6, R_OUT,  32'h0,        4'h0, 32'h0};
    vecs[14] = '{"out_wr2",    1'b1, 1'b1, 3'd6, R_OUT,  32'hA,        4'hA, 32'h0};
    vecs[15] = '{"unmap_wr",   1'b1, 1'b1, 3'd6, 4'hF,   32'hFFFFFFFF, 4'hA, 32'h0};
    vecs[16] = '{"rise_en_rd", 1'b0, 1'b1, 3'd6, R_RISE, 32'h0,        4'hA, 32'hF};
    vecs[17] = '{"ctrl_rd",    1'b0, 1'b1, 3'd6, R_CTRL, 32'h0,        4'hA, 32'h0};

    rst = 1'b1; state = 3'd0; enabled = 1'b0; load_enable = 1'b0; store_enable = 1'b0;
    address = 32'd0; data_in = 32'd0; in_pins = 4'hF;
    #2;
    check("rst_pins", 32'(out_pins), 32'h0);
    check("rst_dout", data_out, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin held high through reset: its rise is dropped while RISE_EN is 0
    idle(5);
    wr_reg(R_RISE, 32'hF);
    rd_reg("post_rst_status", R_STAT, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);
    rd_reg("post_rst_in", R_IN, 32'hF);

    for (int i = 0; i < 18; i++) begin
      access(vecs[i].name, vecs[i].wr, vecs[i].en, vecs[i].st, vecs[i].idx, vecs[i].wdata,
             vecs[i].exp_rd);
      check({vecs[i].name, "_pins"}, 32'(out_pins), 32'(vecs[i].exp_pins));
    end

    // Rise on pin0: status and irq appear after the second edge past the first sampling edge
    wr_reg(R_RISE, 32'h1);
    wr_reg(R_CTRL, 32'h1);
    in_pins = 4'h0;
    idle(4);
    check("fall_ignored_irq", 32'(irq), 32'h0);
    in_pins = 4'h1;
    idle(1);
    check("rise_k_irq", 32'(irq), 32'h0);
    idle(1);
    check("rise_k1_irq", 32'(irq), 32'h0);
    idle(1);
    check("rise_k2_irq", 32'(irq), 32'h1);
    rd_reg("rise_status", R_STAT, 32'h1);
    in_pins = 4'h0;
    idle(4);
    rd_reg("fall_no_status", R_STAT, 32'h1);
    wr_reg(R_RISE, 32'h0);
    rd_reg("en_clr_keeps_status", R_STAT, 32'h1);
    wr_reg(R_STAT, 32'h1);
    check("w1c_irq", 32'(irq), 32'h0);

    // Build STATUS=0x3, then W1C bit0 on the same edge as a fresh pin0 rise
    wr_reg(R_RISE, 32'h3);
    in_pins = 4'h3;
    idle(3);
    rd_reg("status3", R_STAT, 32'h3);
    in_pins = 4'h2;
    idle(4);
    in_pins = 4'h3;
    idle(2);
    wr_reg(R_STAT, 32'h1);
    rd_reg("set_wins", R_STAT, 32'h3);
    wr_reg(R_STAT, 32'h1);
    rd_reg("w1c_other_bit", R_STAT, 32'h2);
    check("w1c_other_irq", 32'(irq), 32'h1);
    wr_reg(R_STAT, 32'h3);
    check("w1c_all_irq", 32'(irq), 32'h0);
    rd_reg("w1c_all_status", R_STAT, 32'h0);

    // Falling edge detection on pin1
    wr_reg(R_FALL, 32'h2);
    in_pins = 4'h1;
    idle(4);
    rd_reg("fall_status", R_STAT, 32'h2);
    wr_reg(R_FALL, 32'h0);
    wr_reg(R_STAT, 32'h2);
    rd_reg("fall_cleared", R_STAT, 32'h0);

    // Load data holds between loads
    in_pins = 4'h9;
    idle(4);
    rd_reg("in9", R_IN, 32'h9);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("dout_hold", data_out, 32'h9);
    end
    check("no_status_pin3", 32'(irq), 32'h0);

    // Set up OUT=F and STATUS=0x2, then reset during a store
    wr_reg(R_OUT, 32'hF);
    in_pins = 4'hB;
    idle(4);
    check("stat2_irq", 32'(irq), 32'h1);
    wr_reg(R_CTRL, 32'h0);
    check("irq_masked", 32'(irq), 32'h0);
    wr_reg(R_CTRL, 32'h1);
    check("irq_unmasked", 32'(irq), 32'h1);
    rd_reg("stat2", R_STAT, 32'h2);
    check("pre_rst_pins", 32'(out_pins), 32'hF);
    state = 3'd6; enabled = 1'b1; store_enable = 1'b1;
    address = {26'd0, R_OUT, 2'b00}; data_in = 32'h5;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pins", 32'(out_pins), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_dout", data_out, 32'h0);
    enabled = 1'b0; store_enable = 1'b0; state = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    rd_reg("post_rst2_status", R_STAT, 32'h0);
    rd_reg("post_rst2_rise_en", R_RISE, 32'h0);
    rd_reg("post_rst2_out", R_OUT, 32'h0);
    check("post_rst2_irq", 32'(irq), 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
